multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, memory port and immediate path.
- Drives the 2-bit immediate-format select to the immediate extension unit, plus ALU, mux and write-enable controls.
- Adds a memory ready handshake so variable-latency memory stalls the sequence.

---
 rtl/multicycle_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, stalling on the memory ready handshake.
module multicycle_controller #(
  parameter int unsigned STATE_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [6:0]             op_i,
  input  logic [2:0]             funct3_i,
  input  logic                   funct7b5_i,
  input  logic                   zero_i,
  input  logic                   mem_ready_i,
  output logic                   pc_write_o,
  output logic                   adr_src_o,
  output logic                   mem_write_o,
  output logic                   ir_write_o,
  output logic [1:0]             result_src_o,
  output logic [1:0]             alu_src_a_o,
  output logic [1:0]             alu_src_b_o,
  output logic [2:0]             alu_control_o,
  output logic [1:0]             imm_src_o,
  output logic                   reg_write_o,
  output logic                   illegal_o,
  output logic [STATE_WIDTH-1:0] state_o
);

  typedef enum logic [STATE_WIDTH-1:0] {
    S_FETCH    = STATE_WIDTH'(0),
    S_DECODE   = STATE_WIDTH'(1),
    S_MEMADR   = STATE_WIDTH'(2),
    S_MEMREAD  = STATE_WIDTH'(3),
    S_MEMWB    = STATE_WIDTH'(4),
    S_MEMWRITE = STATE_WIDTH'(5),
    S_EXECR    = STATE_WIDTH'(6),
    S_EXECI    = STATE_WIDTH'(7),
    S_ALUWB    = STATE_WIDTH'(8),
    S_BEQ      = STATE_WIDTH'(9),
    S_JAL      = STATE_WIDTH'(10)
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e     state_q;
  state_e     state_d;
  logic [2:0] alu_funct;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

  // Only R-type (op[5] set) subtracts on funct7b5; for I-type that bit is immediate.
  always_comb begin
    alu_funct = ALU_ADD;
    case (funct3_i)
      3'b000:  alu_funct = (op_i[5] && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_funct = ALU_SLT;
      3'b110:  alu_funct = ALU_OR;
      3'b111:  alu_funct = ALU_AND;
      default: alu_funct = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_src_o = 2'b00;
    case (op_i)
      OP_STORE: imm_src_o = 2'b01;
      OP_BEQ:   imm_src_o = 2'b10;
      OP_JAL:   imm_src_o = 2'b11;
      default:  imm_src_o = 2'b00;
    endcase
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_write_o    = 1'b0;
    adr_src_o     = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    result_src_o  = 2'b00;
    alu_src_a_o   = 2'b00;
    alu_src_b_o   = 2'b00;
    alu_control_o = ALU_ADD;
    reg_write_o   = 1'b0;
    illegal_o     = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
        state_d      = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_o = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_o = 1'b1;
        state_d   = mem_ready_i ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
        state_d     = mem_ready_i ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = alu_funct;
        state_d       = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_o   = 2'b10;
        alu_src_b_o   = 2'b01;
        alu_control_o = alu_funct;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = ALU_SUB;
        pc_write_o    = zero_i;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
        state_d     = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset presents FETCH datapath selects with every strobe held low.
    if (!rst_n_i) begin
      pc_write_o    = 1'b0;
      adr_src_o     = 1'b0;
      mem_write_o   = 1'b0;
      ir_write_o    = 1'b0;
      result_src_o  = 2'b10;
      alu_src_a_o   = 2'b00;
      alu_src_b_o   = 2'b10;
      alu_control_o = ALU_ADD;
      reg_write_o   = 1'b0;
      illegal_o     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector table for multicycle_controller plus bounded memory-stall sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7;
  logic       zero;
  logic       rdy;
  logic       pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o, illegal_o;
  logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o;
  logic [2:0] alu_control_o;
  logic [3:0] state_o;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_WIDTH(4)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .op_i         (op),
    .funct3_i     (f3),
    .funct7b5_i   (f7),
    .zero_i       (zero),
    .mem_ready_i  (rdy),
    .pc_write_o   (pc_write_o),
    .adr_src_o    (adr_src_o),
    .mem_write_o  (mem_write_o),
    .ir_write_o   (ir_write_o),
    .result_src_o (result_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_control_o(alu_control_o),
    .imm_src_o    (imm_src_o),
    .reg_write_o  (reg_write_o),
    .illegal_o    (illegal_o),
    .state_o      (state_o)
  );

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BQ  = 7'b1100011;
  localparam logic [6:0] OP_JL  = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  // Field order: pc_wr adr mem_wr ir_wr result srcA srcB alu imm reg_wr illegal
  localparam logic [16:0] F1_I00  = 17'b1_0_0_1_10_00_10_000_00_0_0;
  localparam logic [16:0] F1_I01  = 17'b1_0_0_1_10_00_10_000_01_0_0;
  localparam logic [16:0] F1_I10  = 17'b1_0_0_1_10_00_10_000_10_0_0;
  localparam logic [16:0] F1_I11  = 17'b1_0_0_1_10_00_10_000_11_0_0;
  localparam logic [16:0] F0_I00  = 17'b0_0_0_0_10_00_10_000_00_0_0;
  localparam logic [16:0] F0_I01  = 17'b0_0_0_0_10_00_10_000_01_0_0;
  localparam logic [16:0] D_I00   = 17'b0_0_0_0_00_01_01_000_00_0_0;
  localparam logic [16:0] D_I01   = 17'b0_0_0_0_00_01_01_000_01_0_0;
  localparam logic [16:0] D_I10   = 17'b0_0_0_0_00_01_01_000_10_0_0;
  localparam logic [16:0] D_I11   = 17'b0_0_0_0_00_01_01_000_11_0_0;
  localparam logic [16:0] D_ILL   = 17'b0_0_0_0_00_01_01_000_00_0_1;
  localparam logic [16:0] EXR_ADD = 17'b0_0_0_0_00_10_00_000_00_0_0;
  localparam logic [16:0] EXR_SUB = 17'b0_0_0_0_00_10_00_001_00_0_0;
  localparam logic [16:0] EXR_OR  = 17'b0_0_0_0_00_10_00_011_00_0_0;
  localparam logic [16:0] EXI_ADD = 17'b0_0_0_0_00_10_01_000_00_0_0;
  localparam logic [16:0] EXI_SLT = 17'b0_0_0_0_00_10_01_101_00_0_0;
  localparam logic [16:0] EXI_AND = 17'b0_0_0_0_00_10_01_010_00_0_0;
  localparam logic [16:0] AWB_I00 = 17'b0_0_0_0_00_00_00_000_00_1_0;
  localparam logic [16:0] AWB_I11 = 17'b0_0_0_0_00_00_00_000_11_1_0;
  localparam logic [16:0] MA_I00  = 17'b0_0_0_0_00_10_01_000_00_0_0;
  localparam logic [16:0] MA_I01  = 17'b0_0_0_0_00_10_01_000_01_0_0;
  localparam logic [16:0] MRD     = 17'b0_1_0_0_00_00_00_000_00_0_0;
  localparam logic [16:0] MWB     = 17'b0_0_0_0_01_00_00_000_00_1_0;
  localparam logic [16:0] MWR     = 17'b0_1_1_0_00_00_00_000_01_0_0;
  localparam logic [16:0] BEQ_T   = 17'b1_0_0_0_00_10_00_001_10_0_0;
  localparam logic [16:0] BEQ_N   = 17'b0_0_0_0_00_10_00_001_10_0_0;
  localparam logic [16:0] JAL_C   = 17'b1_0_0_0_00_01_10_000_11_0_0;

  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [6:0] o, input logic [2:0] a, input logic b,
                     input logic z, input logic y, input logic [3:0] s, input logic [16:0] c);
    vec_t v;
    v = '{r, o, a, b, z, y, s, c};
    tv.push_back(v);
  endtask

  function automatic logic [16:0] ctl_now();
    return {pc_write_o, adr_src_o, mem_write_o, ir_write_o, result_src_o, alu_src_a_o,
            alu_src_b_o, alu_control_o, imm_src_o, reg_write_o, illegal_o};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got state/ctl %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one load/store from FETCH, holding ready low for 'delay' cycles in the memory state.
  task automatic run_mem(input string name, input logic [6:0] o, input int unsigned delay,
                         input int unsigned exp_mw, input int unsigned exp_rw);
    int unsigned mw = 0, rw = 0, mem_cyc = 0;
    bit left = 1'b0, done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      op = o; f3 = 3'b010; f7 = 1'b0; zero = 1'b0;
      if (state_o == 4'd3 || state_o == 4'd5) begin
        rdy = (mem_cyc >= delay);
        mem_cyc++;
      end else begin
        rdy = 1'b1;
      end
      #1;
      if (mem_write_o) mw++;
      if (reg_write_o) rw++;
      if (state_o != 4'd0) left = 1'b1;
      else if (left) done = 1'b1;
    end
    check_int({name, " completes"}, int'(done), 1);
    check_int({name, " mem cycles"}, mem_cyc, delay + 1);
    check_int({name, " mem_write cycles"}, mw, exp_mw);
    check_int({name, " reg_write cycles"}, rw, exp_rw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op = OP_R; f3 = 3'b000; f7 = 1'b0; zero = 1'b0; rdy = 1'b1;

    add(0, OP_R,   3'b000, 0, 0, 1, 4'd0,  F0_I00);
    add(1, OP_R,   3'b000, 0, 0, 1, 4'd0,  F1_I00);
    add(1, OP_R,   3'b000, 0, 0, 1, 4'd1,  D_I00);
    add(1, OP_R,   3'b000, 0, 0, 1, 4'd6,  EXR_ADD);
    add(1, OP_R,   3'b000, 0, 0, 1, 4'd8,  AWB_I00);
    add(1, OP_R,   3'b000, 1, 0, 0, 4'd0,  F0_I00);
    add(1, OP_R,   3'b000, 1, 0, 1, 4'd0,  F1_I00);
    add(1, OP_R,   3'b000, 1, 0, 1, 4'd1,  D_I00);
    add(1, OP_R,   3'b000, 1, 0, 1, 4'd6,  EXR_SUB);
    add(1, OP_R,   3'b000, 1, 0, 1, 4'd8,  AWB_I00);
    add(1, OP_R,   3'b110, 0, 0, 1, 4'd0,  F1_I00);
    add(1, OP_R,   3'b110, 0, 0, 1, 4'd1,  D_I00);
    add(1, OP_R,   3'b110, 0, 0, 1, 4'd6,  EXR_OR);
    add(1, OP_R,   3'b110, 0, 0, 1, 4'd8,  AWB_I00);
    add(1, OP_I,   3'b000, 1, 0, 1, 4'd0,  F1_I00);
    add(1, OP_I,   3'b000, 1, 0, 1, 4'd1,  D_I00);
    add(1, OP_I,   3'b000, 1, 0, 1, 4'd7,  EXI_ADD);
    add(1, OP_I,   3'b000, 1, 0, 1, 4'd8,  AWB_I00);
    add(1, OP_I,   3'b010, 0, 0, 1, 4'd0,  F1_I00);
    add(1, OP_I,   3'b010, 0, 0, 1, 4'd1,  D_I00);
    add(1, OP_I,   3'b010, 0, 0, 1, 4'd7,  EXI_SLT);
    add(1, OP_I,   3'b010, 0, 0, 1, 4'd8,  AWB_I00);
    add(1, OP_I,   3'b111, 0, 0, 1, 4'd0,  F1_I00);
    add(1, OP_I,   3'b111, 0, 0, 1, 4'd1,  D_I00);
    add(1, OP_I,   3'b111, 0, 0, 1, 4'd7,  EXI_AND);
    add(1, OP_I,   3'b111, 0, 0, 1, 4'd8,  AWB_I00);
    add(1, OP_LW,  3'b010, 0, 0, 1, 4'd0,  F1_I00);
    add(1, OP_LW,  3'b010, 0, 0, 0, 4'd1,  D_I00);
    add(1, OP_LW,  3'b010, 0, 0, 0, 4'd2,  MA_I00);
    add(1, OP_LW,  3'b010, 0, 0, 0, 4'd3,  MRD);
    add(1, OP_LW,  3'b010, 0, 0, 0, 4'd3,  MRD);
    add(1, OP_LW,  3'b010, 0, 0, 0, 4'd3,  MRD);
    add(1, OP_LW,  3'b010, 0, 0, 1, 4'd3,  MRD);
    add(1, OP_LW,  3'b010, 0, 0, 1, 4'd4,  MWB);
    add(1, OP_SW,  3'b010, 0, 0, 1, 4'd0,  F1_I01);
    add(1, OP_SW,  3'b010, 0, 0, 1, 4'd1,  D_I01);
    add(1, OP_SW,  3'b010, 0, 0, 1, 4'd2,  MA_I01);
    add(1, OP_SW,  3'b010, 0, 0, 0, 4'd5,  MWR);
    add(1, OP_SW,  3'b010, 0, 0, 0, 4'd5,  MWR);
    add(1, OP_SW,  3'b010, 0, 0, 1, 4'd5,  MWR);
    add(1, OP_BQ,  3'b000, 0, 1, 1, 4'd0,  F1_I10);
    add(1, OP_BQ,  3'b000, 0, 1, 1, 4'd1,  D_I10);
    add(1, OP_BQ,  3'b000, 0, 1, 1, 4'd9,  BEQ_T);
    add(1, OP_BQ,  3'b000, 0, 0, 1, 4'd0,  F1_I10);
    add(1, OP_BQ,  3'b000, 0, 0, 1, 4'd1,  D_I10);
    add(1, OP_BQ,  3'b000, 0, 0, 1, 4'd9,  BEQ_N);
    add(1, OP_JL,  3'b000, 0, 0, 1, 4'd0,  F1_I11);
    add(1, OP_JL,  3'b000, 0, 0, 1, 4'd1,  D_I11);
    add(1, OP_JL,  3'b000, 0, 0, 1, 4'd10, JAL_C);
    add(1, OP_JL,  3'b000, 0, 0, 1, 4'd8,  AWB_I11);
    add(1, OP_SYS, 3'b000, 0, 0, 1, 4'd0,  F1_I00);
    add(1, OP_SYS, 3'b000, 0, 0, 1, 4'd1,  D_ILL);
    add(1, OP_SYS, 3'b000, 0, 0, 0, 4'd0,  F0_I00);
    add(1, OP_SW,  3'b010, 0, 0, 1, 4'd0,  F1_I01);
    add(1, OP_SW,  3'b010, 0, 0, 1, 4'd1,  D_I01);
    add(1, OP_SW,  3'b010, 0, 0, 1, 4'd2,  MA_I01);
    add(1, OP_SW,  3'b010, 0, 0, 0, 4'd5,  MWR);
    add(0, OP_SW,  3'b010, 0, 0, 0, 4'd5,  F0_I01);
    add(1, OP_SW,  3'b010, 0, 0, 0, 4'd0,  F0_I01);

    @(posedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst_n = tv[i].rst_n; op = tv[i].op; f3 = tv[i].f3; f7 = tv[i].f7;
      zero = tv[i].zero; rdy = tv[i].rdy;
      #1;
      check($sformatf("vec%0d", i), {state_o, ctl_now()}, {tv[i].st, tv[i].ctl});
    end

    run_mem("lw stall3", OP_LW, 3, 0, 1);
    run_mem("sw stall2", OP_SW, 2, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
